// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: widths, ALU op encoding, opcodes,
// funct7 values and the ID/EX pipeline payload.
package rv32i_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned REG_AW = 5;

  // ALU op encoding shared with execute
  localparam logic [OP_W-1:0] ALU_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] ALU_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] ALU_AND  = OP_W'(2);
  localparam logic [OP_W-1:0] ALU_OR   = OP_W'(3);
  localparam logic [OP_W-1:0] ALU_XOR  = OP_W'(4);
  localparam logic [OP_W-1:0] ALU_SLL  = OP_W'(5);
  localparam logic [OP_W-1:0] ALU_SRL  = OP_W'(6);
  localparam logic [OP_W-1:0] ALU_SRA  = OP_W'(7);
  localparam logic [OP_W-1:0] ALU_SLT  = OP_W'(8);
  localparam logic [OP_W-1:0] ALU_SLTU = OP_W'(9);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ID/EX register contents
  typedef struct packed {
    logic [XLEN-1:0]   alu_a;
    logic [XLEN-1:0]   alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              is_branch;
    logic [2:0]        br_funct3;
    logic              is_load;
    logic              is_store;
    logic              is_jump;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   store_data;
    logic              illegal;
  } idex_t;

  // funct3 to ALU op for OP/OP-IMM; alt selects sub/sra
  function automatic logic [OP_W-1:0] alu_op_of(input logic [2:0] f3, input logic alt);
    logic [OP_W-1:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: sign-extended I/S/B/U/J immediate selected by opcode.
// Ports: instr (instruction word) in, imm (XLEN immediate, 0 for R-type/unknown) out.
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (instr[6:0])
      OPC_OPIMM, OPC_LOAD, OPC_JALR:
        imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = XLEN'($signed({instr[31:12], 12'b0}));
      OPC_JAL:
        imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage feeding the ALU through a registered ID/EX stage.
// Ports: clk/rst_n; flush; fetch side in_valid/in_ready/instr/pc;
// register-file port rs1_addr/rs2_addr (comb) and rs1_data/rs2_data;
// execute side out_valid/out_ready plus the registered decoded fields.
module decode_stage
  import rv32i_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [XLEN-1:0]   pc,
  output logic [REG_AW-1:0] rs1_addr,
  output logic [REG_AW-1:0] rs2_addr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [REG_AW-1:0] rd,
  output logic              reg_write,
  output logic              is_branch,
  output logic [2:0]        br_funct3,
  output logic              is_load,
  output logic              is_store,
  output logic              is_jump,
  output logic [XLEN-1:0]   imm,
  output logic [XLEN-1:0]   pc_q,
  output logic [XLEN-1:0]   store_data,
  output logic              illegal
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state_q, state_d;
  idex_t           q, d;
  logic [XLEN-1:0] imm_c;
  logic            capture;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;

  imm_gen u_imm_gen (.instr(instr), .imm(imm_c));

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  assign in_ready = (state_q == EMPTY) || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // Next state: flush wins, then capture, then drain
  always_comb begin
    state_d = state_q;
    if (flush)
      state_d = EMPTY;
    else if (capture)
      state_d = FULL;
    else if ((state_q == FULL) && out_ready)
      state_d = EMPTY;
  end

  // Instruction decode into the next ID/EX payload
  always_comb begin
    d            = '0;
    d.alu_a      = rs1_data;
    d.alu_b      = rs2_data;
    d.alu_op     = ALU_ADD;
    d.rd         = instr[11:7];
    d.br_funct3  = funct3;
    d.imm        = imm_c;
    d.pc         = pc;
    d.store_data = rs2_data;
    case (opcode)
      OPC_OP: begin
        d.reg_write = 1'b1;
        d.alu_op    = alu_op_of(funct3, funct7 == F7_ALT);
        d.illegal   = !((funct7 == F7_ZERO) ||
                        ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_OPIMM: begin
        d.reg_write = 1'b1;
        d.alu_b     = imm_c;
        d.alu_op    = alu_op_of(funct3, (funct3 == 3'b101) && instr[30]);
        if (funct3 == 3'b001) begin
          d.alu_b   = XLEN'(instr[24:20]);
          d.illegal = (funct7 != F7_ZERO);
        end else if (funct3 == 3'b101) begin
          // Shift amount only; instr[30] is the sra select, not part of b
          d.alu_b   = XLEN'(instr[24:20]);
          d.illegal = ((funct7 & 7'b1011111) != F7_ZERO);
        end
      end
      OPC_LUI: begin
        d.reg_write = 1'b1;
        d.alu_a     = '0;
        d.alu_b     = imm_c;
      end
      OPC_AUIPC: begin
        d.reg_write = 1'b1;
        d.alu_a     = pc;
        d.alu_b     = imm_c;
      end
      OPC_JAL, OPC_JALR: begin
        // ALU computes the link address; target uses imm
        d.reg_write = 1'b1;
        d.is_jump   = 1'b1;
        d.alu_a     = pc;
        d.alu_b     = XLEN'(4);
      end
      OPC_BRANCH: begin
        d.is_branch = 1'b1;
        case (funct3[2:1])
          2'b00:   d.alu_op = ALU_SUB;
          2'b10:   d.alu_op = ALU_SLT;
          2'b11:   d.alu_op = ALU_SLTU;
          default: d.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d.reg_write = 1'b1;
        d.is_load   = 1'b1;
        d.alu_b     = imm_c;
      end
      OPC_STORE: begin
        d.is_store = 1'b1;
        d.alu_b    = imm_c;
      end
      default: d.illegal = 1'b1;
    endcase
    if (d.illegal) begin
      d.reg_write = 1'b0;
      d.is_branch = 1'b0;
      d.is_load   = 1'b0;
      d.is_store  = 1'b0;
      d.is_jump   = 1'b0;
      d.alu_op    = ALU_ADD;
    end
    if (d.rd == '0)
      d.reg_write = 1'b0;
  end

  // State and ID/EX register; payload only loads on capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      q       <= '0;
    end else begin
      state_q <= state_d;
      if (capture)
        q <= d;
    end
  end

  assign out_valid  = (state_q == FULL);
  assign alu_a      = q.alu_a;
  assign alu_b      = q.alu_b;
  assign alu_op     = q.alu_op;
  assign rd         = q.rd;
  assign reg_write  = q.reg_write;
  assign is_branch  = q.is_branch;
  assign br_funct3  = q.br_funct3;
  assign is_load    = q.is_load;
  assign is_store   = q.is_store;
  assign is_jump    = q.is_jump;
  assign imm        = q.imm;
  assign pc_q       = q.pc;
  assign store_data = q.store_data;
  assign illegal    = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed scoreboard bench for decode_stage.
module tb_decode_stage;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, rd;
  logic [31:0] alu_a, alu_b, imm, pc_q, store_data;
  logic [3:0]  alu_op;
  logic [2:0]  br_funct3;
  logic        reg_write, is_branch, is_load, is_store, is_jump, illegal;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a, b, imm, pc, sd;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw, br, ld, st, jp, ill, chk_ab, chk_imm;
  } exp_t;

  exp_t sb[$];

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .rd(rd),
    .reg_write(reg_write), .is_branch(is_branch), .br_funct3(br_funct3),
    .is_load(is_load), .is_store(is_store), .is_jump(is_jump),
    .imm(imm), .pc_q(pc_q), .store_data(store_data), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [31:0] a, b, im, p, sd,
                          input logic [3:0] op, input logic [4:0] r,
                          input logic rw, br, ld, st, jp, ill, cab, cim);
    exp_t e;
    e.a = a; e.b = b; e.imm = im; e.pc = p; e.sd = sd; e.op = op; e.rd = r;
    e.rw = rw; e.br = br; e.ld = ld; e.st = st; e.jp = jp; e.ill = ill;
    e.chk_ab = cab; e.chk_imm = cim;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [31:0] i, p, r1, r2);
    instr = i; pc = p; rs1_data = r1; rs2_data = r2; in_valid = 1'b1;
  endtask

  task automatic compare_front(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    if (e.chk_ab) begin
      chk({tag, "_alu_a"}, alu_a, e.a);
      chk({tag, "_alu_b"}, alu_b, e.b);
    end
    chk({tag, "_alu_op"},    32'(alu_op),    32'(e.op));
    chk({tag, "_rd"},        32'(rd),        32'(e.rd));
    chk({tag, "_reg_write"}, 32'(reg_write), 32'(e.rw));
    chk({tag, "_is_branch"}, 32'(is_branch), 32'(e.br));
    chk({tag, "_is_load"},   32'(is_load),   32'(e.ld));
    chk({tag, "_is_store"},  32'(is_store),  32'(e.st));
    chk({tag, "_is_jump"},   32'(is_jump),   32'(e.jp));
    chk({tag, "_illegal"},   32'(illegal),   32'(e.ill));
    chk({tag, "_pc_q"},      pc_q,           e.pc);
    chk({tag, "_store_data"}, store_data,    e.sd);
    if (e.chk_imm) chk({tag, "_imm"}, imm, e.imm);
  endtask

  // Present one instruction, wait (bounded) for acceptance, check ID/EX
  task automatic issue(input string tag, input logic [31:0] i, p, r1, r2);
    int n;
    out_ready = 1'b1;
    drive(i, p, r1, r2);
    n = 0;
    #1;
    while (in_ready !== 1'b1 && n < 20) begin
      tick;
      #1;
      n++;
    end
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    compare_front(tag);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    tick; tick;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_a",     alu_a,          32'd0);
    chk("rst_alu_b",     alu_b,          32'd0);
    chk("rst_alu_op",    32'(alu_op),    32'd0);
    chk("rst_reg_write", 32'(reg_write), 32'd0);
    chk("rst_imm",       imm,            32'd0);
    chk("rst_pc_q",      pc_q,           32'd0);
    chk("rst_illegal",   32'(illegal),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;
    tick;

    // add x3,x1,x2
    drive(32'h002081B3, 32'h1000, 32'd5, 32'd7);
    #1;
    chk("add_rs1_addr", 32'(rs1_addr), 32'd1);
    chk("add_rs2_addr", 32'(rs2_addr), 32'd2);
    push_exp(32'd5, 32'd7, 32'd0, 32'h1000, 32'd7, 4'd0, 5'd3, 1,0,0,0,0,0, 1,0);
    issue("add", 32'h002081B3, 32'h1000, 32'd5, 32'd7);
    chk("add_alu_sum", alu_a + alu_b, 32'd12);

    push_exp(32'd5, 32'd7, 32'd0, 32'h1004, 32'd7, 4'd1, 5'd3, 1,0,0,0,0,0, 1,0);
    issue("sub", 32'h402081B3, 32'h1004, 32'd5, 32'd7);

    push_exp(32'hFFFFFFF8, 32'd3, 32'h403, 32'h1008, 32'd0, 4'd7, 5'd5, 1,0,0,0,0,0, 1,1);
    issue("srai", 32'h40335293, 32'h1008, 32'hFFFFFFF8, 32'd0);

    // Back-pressure: srai held for 3 cycles while addi waits
    push_exp(32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h100C, 32'd0, 4'd0, 5'd1, 1,0,0,0,0,0, 1,1);
    out_ready = 1'b0;
    drive(32'hFFF00093, 32'h100C, 32'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      rs1_data = 32'h99 + 32'(k);
      tick;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_alu_a",     alu_a,          32'hFFFFFFF8);
      chk("hold_alu_b",     alu_b,          32'd3);
      chk("hold_alu_op",    32'(alu_op),    32'd7);
      chk("hold_rd",        32'(rd),        32'd5);
    end
    rs1_data = 32'd0;
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    compare_front("addi_nobubble");

    push_exp(32'd0, 32'h12345000, 32'h12345000, 32'h1010, 32'h66, 4'd0, 5'd7, 1,0,0,0,0,0, 1,1);
    issue("lui", 32'h123453B7, 32'h1010, 32'h55, 32'h66);

    push_exp(32'd0, 32'd0, 32'd0, 32'h1014, 32'd0, 4'd0, 5'd0, 0,0,0,0,0,0, 1,1);
    issue("nop_rd0", 32'h00000013, 32'h1014, 32'd0, 32'd0);

    push_exp(32'd3, 32'd3, 32'd8, 32'h1018, 32'd3, 4'd1, 5'd8, 0,1,0,0,0,0, 1,1);
    issue("beq", 32'h00208463, 32'h1018, 32'd3, 32'd3);

    push_exp(32'd1, 32'd2, 32'd8, 32'h101C, 32'd2, 4'd9, 5'd8, 0,1,0,0,0,0, 1,1);
    issue("bltu", 32'h0020E463, 32'h101C, 32'd1, 32'd2);

    push_exp(32'h2000, 32'd4, 32'd8, 32'h2000, 32'd0, 4'd0, 5'd1, 1,0,0,0,1,0, 1,1);
    issue("jal", 32'h008000EF, 32'h2000, 32'h77, 32'd0);

    push_exp(32'h100, 32'd4, 32'd4, 32'h2004, 32'hDEADBEEF, 4'd0, 5'd4, 0,0,0,1,0,0, 1,1);
    issue("sw", 32'h0020A223, 32'h2004, 32'h100, 32'hDEADBEEF);

    // Flush while FULL with an incoming instruction
    out_ready = 1'b0;
    drive(32'h002081B3, 32'h2008, 32'd1, 32'd1);
    flush = 1'b1;
    tick;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    tick;
    chk("flush_dropped", 32'(out_valid), 32'd0);

    push_exp(32'd0, 32'd0, 32'd0, 32'h3000, 32'd0, 4'd0, 5'd0, 0,0,0,0,0,1, 0,0);
    issue("illegal_opc", 32'h0000007F, 32'h3000, 32'd0, 32'd0);
    tick;
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Async reset while holding
    push_exp(32'd5, 32'd7, 32'd0, 32'h4000, 32'd7, 4'd0, 5'd3, 1,0,0,0,0,0, 1,0);
    issue("pre_rst", 32'h002081B3, 32'h4000, 32'd5, 32'd7);
    out_ready = 1'b0;
    tick;
    chk("pre_rst_hold", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_alu_a",     alu_a,          32'd0);
    chk("mid_rst_in_ready",  32'(in_ready),  32'd1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
